gsau_operand_issue: RTL
=======================

// Module: gsau_operand_issue
// PURPOSE
//  Feed side of the GSAU; the drain side is gsau_control_unit. Accepts one GEMM issue from the scoreboard.
//  Streams the A (weight), B (input) and C (partial-sum) rows out of the veggie register file.
//  Pushes those rows into the systolic-array input FIFO, stalling on sa_fifo_has_space.
//  After the last row it hands the destination tag to gsau_control_unit on sb_nvalid/sb_nvdst.
// PARAMETERS
//  VEGGIEREGS  256  number of veggie registers; REGW = $clog2(VEGGIEREGS)
//  ROWS        8    rows per operand; one row occupies one register
//  DATAW       512  row width in bits; equals the sa_array_output width
//  BUFDEPTH    2    depth of the read-response buffer; sets the maximum reads in flight
// PORTS
//  CLK              in   1      clock
//  nRST             in   1      asynchronous active-low reset
//  flush            in   1      abort the current instruction
//  instr_valid      in   1      issue request from scoreboard
//  instr_ready      out  1      issuer idle; request accepted when valid&ready
//  instr_srca       in   REGW   base register of A
//  instr_srcb       in   REGW   base register of B
//  instr_srcc       in   REGW   base register of C
//  instr_dst        in   REGW   writeback destination
//  rf_req_valid     out  1      register-file read request
//  rf_req_ready     in   1      register file accepts the request
//  rf_raddr         out  REGW   read address
//  rf_resp_valid    in   1      read data returning, in request order
//  rf_rdata         in   DATAW  read data
//  sa_fifo_has_space in  1      SA input FIFO can take one row this cycle
//  sa_push          out  1      write one row to the SA input FIFO
//  sa_wdata         out  DATAW  row data
//  sa_wsel          out  2      operand select: 0=A, 1=B, 2=C
//  sb_nvalid        out  1      one-cycle pulse: instruction fully dispatched
//  sb_nvdst         out  REGW   destination tag, valid with sb_nvalid
// BEHAVIOUR
//  Reset values: all outputs 0, except instr_ready=1. FSM state IDLE. Counters and buffer cleared.
//  FSM states and transitions:
//   IDLE -> RUN on instr_valid&instr_ready. The operand bases and dst are latched.
//   RUN  -> DONE after the 3*ROWS-th sa_push.
//   DONE -> IDLE after one cycle; sb_nvalid=1 in DONE only.
//  instr_ready is 1 only in IDLE.
//  Read order, for r = 0..ROWS-1: A[r], B[r], C[r]. So the 3*ROWS requests interleave the operands row by row.
//  Address = base + r, modulo VEGGIEREGS; 255+1 wraps to 0.
//  Request counter: rf_req_valid is high in RUN while requests remain AND (outstanding + buffered) < BUFDEPTH.
//  A request advances only on rf_req_valid & rf_req_ready.
//  rf_raddr is combinational from the request counter and is stable while it waits for ready.
//  Responses enter the BUFDEPTH-entry FIFO. Overflow is impossible by credit. rf_resp_valid with no request outstanding is illegal (assertion).
//  Push: sa_push = buffer nonempty & sa_fifo_has_space & state==RUN.
//  sa_wdata and sa_wsel come from the buffer head. sa_wsel is tracked by a push counter mod 3.
//  Push order equals request order.
//  Latency: request goes out the cycle after accept. A response at cycle t can push at t+1 at the earliest.
//   sb_nvalid is asserted the cycle after the final push.
//  Simultaneous push and response: the buffer count is unchanged, and the credit frees the same cycle.
//  has_space low mid-stream: pushes hold; requests continue until credit is exhausted; no row is lost or duplicated.
//  flush, any state: next state IDLE and the buffer is cleared. sb_nvalid is suppressed if flush arrives in DONE.
//   Responses still outstanding are counted and discarded, and are not pushed. instr_ready stays 0 until the outstanding count is 0.
//  flush has priority over instr_valid in the same cycle.
//  Async reset mid-RUN: everything returns to the reset values immediately.
// STRUCTURE
//  sys_arr_pkg gets: the issue_state_t enum {IDLE,RUN,DONE}; operand_sel_t (A=0, B=1, C=2);
//   the ROWS and DATAW constants; and the sa_issue_t packed struct {srca, srcb, srcc, dst}.
//  One sub-module: gsau_resp_buf, a parameterised BUFDEPTH x DATAW sync FIFO with push/pop/count/clear.
// TESTING
//  1 Basic: srca=8'h10, srcb=8'h20, srcc=8'h30, dst=8'h0A; rf latency 1; always ready and has_space.
//    -> 24 pushes; addresses 10,20,30,11,21,31,...; sa_wsel 0,1,2 repeating.
//    -> sb_nvalid exactly once, with sb_nvdst=0A, one cycle after the last push.
//  2 Wrap: srca=8'hFE.
//    -> A rows read FE, FF, 00..05; data order matches.
//  3 Backpressure: has_space low for 10 cycles mid-stream.
//    -> at most BUFDEPTH requests in flight; pushes resume in order; 24 total pushes; no duplicates.
//  4 RF stall: rf_req_ready low on alternate cycles, rf latency 3.
//    -> rf_raddr held while waiting; output sequence identical to test 1.
//  5 Flush after 7 pushes with 2 reads outstanding.
//    -> no further sa_push; sb_nvalid never asserted; instr_ready returns after the 2 responses.
//    -> a new instruction then runs cleanly.
//  6 Back-to-back: instr_valid held high across two instructions.
//    -> second accepted the cycle after the first sb_nvalid pulse; instr_ready=0 throughout RUN and DONE.

Source files
------------

// File: rtl/sys_arr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_arr_pkg
// Description : Shared types and constants for the GSAU operand issue path.
// Revision    : 1.0
// ============================================================================
package sys_arr_pkg;

    localparam int VEGGIEREGS = 256;
    localparam int REGW       = $clog2(VEGGIEREGS);
    localparam int ROWS       = 8;
    localparam int DATAW      = 512;
    localparam int BUFDEPTH   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } issue_state_t;

    typedef enum logic [1:0] {
        OPSEL_A = 2'd0,
        OPSEL_B = 2'd1,
        OPSEL_C = 2'd2
    } operand_sel_t;

    typedef struct packed {
        logic [REGW-1:0] srca;
        logic [REGW-1:0] srcb;
        logic [REGW-1:0] srcc;
        logic [REGW-1:0] dst;
    } sa_issue_t;

endpackage
`default_nettype wire

// File: rtl/gsau_resp_buf.sv
`default_nettype none
// ============================================================================
// Module      : gsau_resp_buf
// Description : DEPTH x WIDTH synchronous FIFO holding register-file read data.
// Revision    : 1.0
// ============================================================================
module gsau_resp_buf
    import sys_arr_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 512
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int c_PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_PTRW-1:0] r_wptr;
    logic [c_PTRW-1:0] r_rptr;
    logic [c_CNTW-1:0] r_count;

    function automatic logic [c_PTRW-1:0] next_ptr(input logic [c_PTRW-1:0] p);
        return (p == c_PTRW'(DEPTH - 1)) ? '0 : p + c_PTRW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= next_ptr(r_wptr);
            end
            if (i_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + c_CNTW'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - c_CNTW'(1);
            end
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/gsau_operand_issue.sv
`default_nettype none
// ============================================================================
// Module      : gsau_operand_issue
// Description : Streams A/B/C operand rows from the register file into the
//               systolic-array input FIFO, then hands the dst tag onward.
// Revision    : 1.0
// ============================================================================
module gsau_operand_issue
    import sys_arr_pkg::*;
#(
    parameter int ROWS     = sys_arr_pkg::ROWS,
    parameter int DATAW    = sys_arr_pkg::DATAW,
    parameter int BUFDEPTH = sys_arr_pkg::BUFDEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_instr_valid,
    output logic             o_instr_ready,
    input  logic [REGW-1:0]  i_instr_srca,
    input  logic [REGW-1:0]  i_instr_srcb,
    input  logic [REGW-1:0]  i_instr_srcc,
    input  logic [REGW-1:0]  i_instr_dst,
    output logic             o_rf_req_valid,
    input  logic             i_rf_req_ready,
    output logic [REGW-1:0]  o_rf_raddr,
    input  logic             i_rf_resp_valid,
    input  logic [DATAW-1:0] i_rf_rdata,
    input  logic             i_sa_fifo_has_space,
    output logic             o_sa_push,
    output logic [DATAW-1:0] o_sa_wdata,
    output logic [1:0]       o_sa_wsel,
    output logic             o_sb_nvalid,
    output logic [REGW-1:0]  o_sb_nvdst
);
    localparam int c_ROWW  = $clog2(ROWS + 1);
    localparam int c_CNTW  = $clog2(BUFDEPTH + 1);
    localparam int c_PUSHW = $clog2(3 * ROWS + 1);
    localparam logic [c_CNTW:0] c_DEPTH = (c_CNTW + 1)'(BUFDEPTH);

    issue_state_t       r_state;
    issue_state_t       w_state_next;
    sa_issue_t          r_instr;
    logic [c_ROWW-1:0]  r_req_row;
    operand_sel_t       r_req_sel;
    logic [c_PUSHW-1:0] r_push_cnt;
    operand_sel_t       r_push_sel;
    logic [c_CNTW-1:0]  r_outst;
    logic [c_CNTW-1:0]  w_buf_cnt;
    logic [c_CNTW:0]    w_inflight;
    logic [DATAW-1:0]   w_buf_head;
    logic [REGW-1:0]    w_req_base;
    logic               w_accept;
    logic               w_req_hs;
    logic               w_pop;
    logic               w_last_push;
    logic               w_credit;
    logic               w_buf_push;

    assign w_inflight = {1'b0, r_outst} + {1'b0, w_buf_cnt};
    // A pop this cycle frees its slot before the response to this cycle's request can land.
    assign w_credit   = (w_inflight < c_DEPTH) || (w_pop && (w_inflight == c_DEPTH));

    assign w_pop       = (w_buf_cnt != '0) && i_sa_fifo_has_space && (r_state == RUN) && !i_flush;
    assign w_last_push = w_pop && (r_push_cnt == c_PUSHW'(3 * ROWS - 1));
    assign w_accept    = (r_state == IDLE) && (r_outst == '0) && i_instr_valid && !i_flush;
    assign w_buf_push  = i_rf_resp_valid && (r_state == RUN) && !i_flush;
    assign w_req_hs    = o_rf_req_valid && i_rf_req_ready;

    assign o_instr_ready  = (r_state == IDLE) && (r_outst == '0);
    assign o_rf_req_valid = (r_state == RUN) && !i_flush && (r_req_row < c_ROWW'(ROWS)) && w_credit;
    assign o_rf_raddr     = w_req_base + REGW'(r_req_row);
    assign o_sa_push      = w_pop;
    assign o_sa_wdata     = w_pop ? w_buf_head : '0;
    assign o_sa_wsel      = r_push_sel;
    assign o_sb_nvalid    = (r_state == DONE) && !i_flush;
    assign o_sb_nvdst     = r_instr.dst;

    always_comb begin
        w_req_base = r_instr.srcc;
        case (r_req_sel)
            OPSEL_A: w_req_base = r_instr.srca;
            OPSEL_B: w_req_base = r_instr.srcb;
            default: w_req_base = r_instr.srcc;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = RUN;
            RUN:     if (w_last_push) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (i_flush) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= '0;
            r_req_row  <= '0;
            r_req_sel  <= OPSEL_A;
            r_push_cnt <= '0;
            r_push_sel <= OPSEL_A;
        end else if (w_accept) begin
            r_instr    <= '{srca: i_instr_srca, srcb: i_instr_srcb,
                            srcc: i_instr_srcc, dst: i_instr_dst};
            r_req_row  <= '0;
            r_req_sel  <= OPSEL_A;
            r_push_cnt <= '0;
            r_push_sel <= OPSEL_A;
        end else begin
            if (w_req_hs) begin
                if (r_req_sel == OPSEL_C) begin
                    r_req_sel <= OPSEL_A;
                    r_req_row <= r_req_row + c_ROWW'(1);
                end else begin
                    r_req_sel <= operand_sel_t'(r_req_sel + 2'd1);
                end
            end
            if (w_pop) begin
                r_push_cnt <= r_push_cnt + c_PUSHW'(1);
                r_push_sel <= (r_push_sel == OPSEL_C) ? OPSEL_A
                                                      : operand_sel_t'(r_push_sel + 2'd1);
            end
        end
    end

    // Outstanding reads survive flush so late responses can be absorbed and dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outst <= '0;
        end else if (w_req_hs && !i_rf_resp_valid) begin
            r_outst <= r_outst + c_CNTW'(1);
        end else if (!w_req_hs && i_rf_resp_valid) begin
            r_outst <= r_outst - c_CNTW'(1);
        end
    end

    gsau_resp_buf #(
        .DEPTH (BUFDEPTH),
        .WIDTH (DATAW)
    ) u_resp_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (i_flush),
        .i_push  (w_buf_push),
        .i_wdata (i_rf_rdata),
        .i_pop   (w_pop),
        .o_rdata (w_buf_head),
        .o_count (w_buf_cnt)
    );

    a_resp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        i_rf_resp_valid |-> (r_outst != '0));

endmodule
`default_nettype wire
